// File: rtl/oc_monitor.sv
// oc_monitor: multi-channel overcurrent qualifier with latched per-channel faults.
// Optional auto-retry with lockout is built when OC_AUTO_RETRY_EN is defined.
module oc_monitor #(
    parameter int NCH         = 2,
    parameter int TIMEOUT     = 262143,
    parameter int CONTINUOUS  = 1,
    parameter int RETRY_DELAY = 1023,
    parameter int MAX_RETRY   = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] sn,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] oc,
    output logic           oc_any,
    output logic [NCH-1:0] trip_pulse,
    output logic [NCH-1:0] lockout,
    output logic [NCH-1:0] sn_s
);

    typedef enum logic [1:0] {IDLE, QUAL, FAULT, LOCK} state_t;

`ifdef OC_AUTO_RETRY_EN
    localparam int CNT_MAX = (RETRY_DELAY - 1 > TIMEOUT) ? RETRY_DELAY - 1 : TIMEOUT;
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`else
    localparam int CNT_MAX = TIMEOUT;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT);
`ifdef OC_AUTO_RETRY_EN
    localparam logic [CW-1:0] RD_LD = CW'(RETRY_DELAY - 1);
    localparam logic [RW-1:0] MR_V  = RW'(MAX_RETRY);
`endif

    if (NCH < 1 || TIMEOUT < 1 || RETRY_DELAY < 1 || MAX_RETRY < 0) begin : g_bad_cfg
    end

    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sn;
            sync2 <= sync1;
        end
    end

    assign sn_s   = sync2;
    assign oc_any = |oc;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t        st;
        state_t        st_nx;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          flt_nx;
        logic          oc_q;
        logic          tp_q;
`ifdef OC_AUTO_RETRY_EN
        logic [RW-1:0] rc;
        logic [RW-1:0] rc_nx;
        logic          lk_q;
`endif

        always_comb begin
            st_nx  = st;
            cnt_nx = cnt;
`ifdef OC_AUTO_RETRY_EN
            rc_nx  = rc;
`endif
            unique case (st)
                IDLE: begin
                    cnt_nx = '0;
                    if (sn_s[i]) begin
                        st_nx  = QUAL;
                        cnt_nx = TO_LD;
                    end
                end
                QUAL: begin
                    if (cnt == '0) begin
                        if (sn_s[i]) begin
`ifdef OC_AUTO_RETRY_EN
                            if (rc == MR_V) begin
                                st_nx = LOCK;
                            end else begin
                                st_nx  = FAULT;
                                cnt_nx = RD_LD;
                            end
`else
                            st_nx = FAULT;
`endif
                        end else begin
                            st_nx = IDLE;
                        end
                    end else if (CONTINUOUS != 0 && !sn_s[i]) begin
                        // glitch shorter than the window: drop back and rearm
                        st_nx  = IDLE;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                FAULT: begin
`ifdef OC_AUTO_RETRY_EN
                    if (cnt == '0) begin
                        st_nx = IDLE;
                        rc_nx = rc + 1'b1;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
`else
                    st_nx = FAULT;
`endif
                end
                LOCK: st_nx = LOCK;
                default: st_nx = IDLE;
            endcase

            // clear wins over every other transition, including a trip
            if (clr[i]) begin
                st_nx  = IDLE;
                cnt_nx = '0;
`ifdef OC_AUTO_RETRY_EN
                if (st == FAULT || st == LOCK) rc_nx = '0;
`endif
            end
            flt_nx = (st_nx == FAULT) || (st_nx == LOCK);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st   <= IDLE;
                cnt  <= '0;
                oc_q <= 1'b0;
                tp_q <= 1'b0;
            end else begin
                st   <= st_nx;
                cnt  <= cnt_nx;
                oc_q <= flt_nx;
                tp_q <= flt_nx & ~oc_q;
            end
        end

`ifdef OC_AUTO_RETRY_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rc   <= '0;
                lk_q <= 1'b0;
            end else begin
                rc   <= rc_nx;
                lk_q <= (st_nx == LOCK);
            end
        end

        assign lockout[i] = lk_q;
`else
        assign lockout[i] = 1'b0;
`endif
        assign oc[i]         = oc_q;
        assign trip_pulse[i] = tp_q;
    end

endmodule
